// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite responder backed by a bank of NUM_REGS byte-writable registers.
// AW and W are latched independently; every register is also exported on regs_o.
module axi_lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic [ADDR_WIDTH-1:0]          aw_addr,
  input  logic                           aw_valid,
  output logic                           aw_ready,
  input  logic [DATA_WIDTH-1:0]          w_data,
  input  logic [DATA_WIDTH/8-1:0]        w_strb,
  input  logic                           w_valid,
  output logic                           w_ready,
  output logic [1:0]                     b_resp,
  output logic                           b_valid,
  input  logic                           b_ready,
  input  logic [ADDR_WIDTH-1:0]          ar_addr,
  input  logic                           ar_valid,
  output logic                           ar_ready,
  output logic [DATA_WIDTH-1:0]          r_data,
  output logic [1:0]                     r_resp,
  output logic                           r_valid,
  input  logic                           r_ready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned OFS        = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = $clog2(NUM_REGS);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  init_done;
  logic                  aw_hold;
  logic                  w_hold;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  ar_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [IDX_WIDTH-1:0]  wr_idx;
  logic [IDX_WIDTH-1:0]  rd_idx;
  logic                  wr_in_range;
  logic                  rd_in_range;

  assign aw_ready = init_done & ~aw_hold & ~b_valid;
  assign w_ready  = init_done & ~w_hold & ~b_valid;
  assign ar_ready = init_done & ~r_valid;

  assign aw_fire = aw_valid & aw_ready;
  assign w_fire  = w_valid & w_ready;
  assign ar_fire = ar_valid & ar_ready;

  // A held beat takes precedence; otherwise the beat handshaking this edge is used.
  always_comb begin
    wr_addr     = aw_hold ? aw_addr_q : aw_addr;
    wr_data     = w_hold ? w_data_q : w_data;
    wr_strb     = w_hold ? w_strb_q : w_strb;
    commit      = (aw_hold | aw_fire) & (w_hold | w_fire) & ~b_valid;
    wr_idx      = wr_addr[OFS +: IDX_WIDTH];
    rd_idx      = ar_addr[OFS +: IDX_WIDTH];
    wr_in_range = (wr_addr >> (OFS + IDX_WIDTH)) == '0;
    rd_in_range = (ar_addr >> (OFS + IDX_WIDTH)) == '0;
  end

  always_comb begin
    regs_o = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && wr_in_range) begin
      for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) begin
          regs[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      init_done <= 1'b0;
      aw_hold   <= 1'b0;
      w_hold    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_valid   <= 1'b0;
      b_resp    <= RESP_OKAY;
    end else begin
      init_done <= 1'b1;
      if (commit) begin
        aw_hold <= 1'b0;
        w_hold  <= 1'b0;
        b_valid <= 1'b1;
        b_resp  <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_fire) begin
          aw_hold   <= 1'b1;
          aw_addr_q <= aw_addr;
        end
        if (w_fire) begin
          w_hold   <= 1'b1;
          w_data_q <= w_data;
          w_strb_q <= w_strb;
        end
        if (b_valid && b_ready) begin
          b_valid <= 1'b0;
        end
      end
    end
  end

  // Reads sample regs before this edge's commit lands, so same-edge reads see old data.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else if (ar_fire) begin
      r_valid <= 1'b1;
      r_data  <= rd_in_range ? regs[rd_idx] : '0;
      r_resp  <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (r_valid && r_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Scoreboard bench for axi_lite_reg_slave: directed scenarios plus random traffic
// checked against an array-based register model.
module tb_axi_lite_reg_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = DW / 8;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [AW-1:0]   aw_addr;
  logic            aw_valid;
  logic            aw_ready;
  logic [DW-1:0]   w_data;
  logic [SW-1:0]   w_strb;
  logic            w_valid;
  logic            w_ready;
  logic [1:0]      b_resp;
  logic            b_valid;
  logic            b_ready;
  logic [AW-1:0]   ar_addr;
  logic            ar_valid;
  logic            ar_ready;
  logic [DW-1:0]   r_data;
  logic [1:0]      r_resp;
  logic            r_valid;
  logic            r_ready;
  logic [NR*DW-1:0] regs_o;

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .aw_addr(aw_addr), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_strb(w_strb), .w_valid(w_valid), .w_ready(w_ready),
    .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
    .ar_addr(ar_addr), .ar_valid(ar_valid), .ar_ready(ar_ready),
    .r_data(r_data), .r_resp(r_resp), .r_valid(r_valid), .r_ready(r_ready),
    .regs_o(regs_o)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } rd_exp_t;

  int            n_checks = 0;
  int            n_pass = 0;
  logic [1:0]    exp_b[$];
  rd_exp_t       exp_r[$];
  logic [DW-1:0] model [NR];

  function automatic void check(input bit ok, input string name,
                                input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endfunction

  function automatic bit addr_ok(input logic [AW-1:0] a);
    return (a / SW) < NR;
  endfunction

  function automatic void model_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [SW-1:0] s);
    int idx;
    if (addr_ok(a)) begin
      idx = int'(a / SW);
      for (int b = 0; b < SW; b++)
        if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      exp_b.push_back(2'b00);
    end else begin
      exp_b.push_back(2'b10);
    end
  endfunction

  function automatic void push_read(input logic [AW-1:0] a);
    if (addr_ok(a)) exp_r.push_back('{data: model[int'(a / SW)], resp: 2'b00});
    else exp_r.push_back('{data: '0, resp: 2'b10});
  endfunction

  function automatic void check_regs(input string name);
    int bad = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (regs_o[i*DW +: DW] !== model[i]) bad = i;
    if (bad < 0) check(1'b1, name, 0, 0);
    else check(1'b0, name, regs_o[bad*DW +: DW], model[bad]);
  endfunction

  // Response monitor: a handshake is due at the next rising edge when valid and ready are both high.
  always @(negedge aclk) begin
    if (aresetn && b_valid && b_ready) begin
      if (exp_b.size() == 0) check(1'b0, "b_unexpected", b_resp, 0);
      else begin
        logic [1:0] e;
        e = exp_b.pop_front();
        check(b_resp == e, "b_resp", b_resp, e);
      end
    end
    if (aresetn && r_valid && r_ready) begin
      if (exp_r.size() == 0) check(1'b0, "r_unexpected", r_data, 0);
      else begin
        rd_exp_t e;
        e = exp_r.pop_front();
        check(r_data == e.data, "r_data", r_data, e.data);
        check(r_resp == e.resp, "r_resp", r_resp, e.resp);
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                          input int aw_dly, input int w_dly, output int cycles);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    cycles = 0;
    aw_addr = a; w_data = d; w_strb = s;
    while (!(aw_done && w_done) && cycles < 50) begin
      aw_valid = !aw_done && cycles >= aw_dly;
      w_valid  = !w_done && cycles >= w_dly;
      @(negedge aclk);
      if (aw_done) check(aw_ready == 1'b0, "aw_ready_while_held", aw_ready, 0);
      if (w_done)  check(w_ready == 1'b0, "w_ready_while_held", w_ready, 0);
      aw_f = aw_valid && aw_ready;
      w_f  = w_valid && w_ready;
      @(posedge aclk); #1;
      aw_done = aw_done | aw_f;
      w_done  = w_done | w_f;
      cycles++;
    end
    aw_valid = 1'b0; w_valid = 1'b0;
    if (!(aw_done && w_done)) check(1'b0, "write_timeout", cycles, 0);
    else model_write(a, d, s);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int cyc = 0;
    bit f = 0;
    ar_addr = a; ar_valid = 1'b1;
    while (!f && cyc < 50) begin
      @(negedge aclk);
      f = ar_ready;
      @(posedge aclk); #1;
      cyc++;
    end
    ar_valid = 1'b0;
    if (!f) check(1'b0, "read_timeout", cyc, 0);
    else push_read(a);
  endtask

  task automatic drain(input string name);
    int cyc = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0) && cyc < 20) begin
      @(posedge aclk); #1;
      cyc++;
    end
    check(exp_b.size() == 0 && exp_r.size() == 0, "drain", exp_b.size() + exp_r.size(), 0);
    check_regs(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [AW-1:0] a;
    aw_addr = '0; aw_valid = 0; w_data = '0; w_strb = '0; w_valid = 0;
    ar_addr = '0; ar_valid = 0; b_ready = 1; r_ready = 1;
    for (int i = 0; i < NR; i++) model[i] = '0;

    repeat (2) @(posedge aclk); #1;
    check(aw_ready == 0 && w_ready == 0 && ar_ready == 0, "reset_readies",
          {aw_ready, w_ready, ar_ready}, 0);
    check(b_valid == 0 && r_valid == 0 && r_data == 0 && r_resp == 0 && b_resp == 0,
          "reset_resp", {b_valid, r_valid, r_resp, b_resp}, 0);
    check_regs("reset_regs");
    aresetn = 1'b1;
    @(negedge aclk);
    check(aw_ready == 0 && ar_ready == 0, "ready_before_init", {aw_ready, ar_ready}, 0);
    @(posedge aclk); #1;
    check(aw_ready && w_ready && ar_ready, "ready_after_init", {aw_ready, w_ready, ar_ready}, 3'b111);

    // Same-cycle AW/W
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, cyc);
    check(cyc == 1, "t1_accept_cycles", cyc, 1);
    check(b_valid == 1 && b_resp == 2'b00, "t1_b_after_edge", {b_valid, b_resp}, 3'b100);
    check(aw_ready == 0 && w_ready == 0, "t1_readies_low", {aw_ready, w_ready}, 0);
    check(regs_o[2*DW +: DW] == 32'hDEADBEEF, "t1_reg2", regs_o[2*DW +: DW], 32'hDEADBEEF);
    drain("t1_regs");
    do_read(32'h08);
    drain("t1_read");

    // W three cycles ahead of AW, partial strobe
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, cyc);
    drain("t2_preload");
    do_write(32'h0C, 32'h11223344, 4'h5, 3, 0, cyc);
    check(cyc == 4, "t2_accept_cycles", cyc, 4);
    check(b_valid == 1, "t2_commit_at_aw", b_valid, 1);
    check(regs_o[3*DW +: DW] == 32'hAA22CC44, "t2_reg3", regs_o[3*DW +: DW], 32'hAA22CC44);
    drain("t2_regs");

    // Out-of-range accesses
    do_write(32'h40, 32'h55555555, 4'hF, 0, 0, cyc);
    do_write(32'h8000_0004, 32'h66666666, 4'hF, 1, 0, cyc);
    drain("t3_no_change");
    do_read(32'h40);
    do_read(32'h0000_1008);
    drain("t3_read");

    // b_ready held low stalls the next write
    b_ready = 1'b0;
    do_write(32'h10, 32'h12345678, 4'hF, 0, 0, cyc);
    aw_addr = 32'h14; w_data = 32'h9ABCDEF0; w_strb = 4'hF; aw_valid = 1; w_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check(b_valid == 1 && aw_ready == 0 && w_ready == 0, "t4_stall",
            {b_valid, aw_ready, w_ready}, 3'b100);
      @(posedge aclk); #1;
    end
    b_ready = 1'b1;
    do_write(32'h14, 32'h9ABCDEF0, 4'hF, 0, 0, cyc);
    check(cyc == 2, "t4_accept_after_bready", cyc, 2);
    drain("t4_regs");

    // Read and write of reg1 on the same edge
    do_write(32'h04, 32'h7, 4'hF, 0, 0, cyc);
    drain("t5_preload");
    r_ready = 1'b0;
    aw_addr = 32'h04; w_data = 32'h5; w_strb = 4'hF; ar_addr = 32'h04;
    aw_valid = 1; w_valid = 1; ar_valid = 1;
    @(negedge aclk);
    check(aw_ready && w_ready && ar_ready, "t5_all_ready", {aw_ready, w_ready, ar_ready}, 3'b111);
    @(posedge aclk); #1;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    push_read(32'h04);
    model_write(32'h04, 32'h5, 4'hF);
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check(r_valid == 1 && r_data == 32'h7 && r_resp == 2'b00, "t5_r_held",
            r_data, 32'h7);
      @(posedge aclk); #1;
    end
    r_ready = 1'b1;
    drain("t5_regs");
    do_read(32'h04);
    drain("t5_reread");

    // Reset mid-transaction
    aw_addr = 32'h10; aw_valid = 1;
    @(negedge aclk);
    check(aw_ready == 1, "t6_aw_ready", aw_ready, 1);
    @(posedge aclk); #1;
    aw_valid = 0;
    r_ready = 1'b0;
    do_read(32'h08);
    check(r_valid == 1, "t6_r_valid_pending", r_valid, 1);
    #2 aresetn = 1'b0;
    #1;
    check(aw_ready == 0 && w_ready == 0 && ar_ready == 0 && b_valid == 0 && r_valid == 0,
          "t6_reset_ctrl", {aw_ready, w_ready, ar_ready, b_valid, r_valid}, 0);
    check(r_data == 0 && r_resp == 0 && b_resp == 0, "t6_reset_data", r_data, 0);
    check(regs_o == '0, "t6_reset_regs", regs_o[63:0], 0);
    exp_b.delete(); exp_r.delete();
    for (int i = 0; i < NR; i++) model[i] = '0;
    r_ready = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check(aw_ready == 0 && w_ready == 0 && ar_ready == 0 && b_valid == 0, "t6_ready_before_init",
          {aw_ready, w_ready, ar_ready, b_valid}, 0);
    @(posedge aclk); #1;
    check(aw_ready && w_ready && ar_ready, "t6_ready_after_init",
          {aw_ready, w_ready, ar_ready}, 3'b111);
    do_write(32'h14, 32'hCAFEF00D, 4'hF, 2, 0, cyc);
    check(cyc == 3, "t6_no_stale_aw", cyc, 3);
    drain("t6_regs");

    // Random traffic
    for (int n = 0; n < 150; n++) begin
      a = AW'($urandom_range(NR * SW + 7, 0));
      if ($urandom_range(9, 0) == 0) a = a | 32'h0100_0000;
      if ($urandom_range(1, 0) == 1)
        do_write(a, $urandom, SW'($urandom_range(15, 0)), $urandom_range(3, 0),
                 $urandom_range(3, 0), cyc);
      else
        do_read(a);
    end
    drain("random_regs");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
